// File: rtl/bcd_score_counter.sv
// BCD score counter: touch synchroniser, up/down counting with saturate or
// wrap on overflow, sticky best score, and a multiplexed 7-seg scan driver.
module bcd_score_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SATURATE = 1,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned LZB      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  touch,
  input  logic                  dec,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   best,
  output logic                  ovf,
  output logic                  wrap,
  output logic [DIGITS-1:0]     ssd_ctl,
  output logic [3:0]            ssd_digit,
  output logic                  ssd_blank
);

  localparam int unsigned SW    = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic             s1, s2, s3;
  logic             inc;
  logic             all_nines;
  logic             is_zero;
  logic [SW-1:0]    score_nxt;
  logic             ovf_nxt;
  logic             wrap_nxt;
  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] msd;
  logic             blank;

  // BCD +1 with ripple carry; each digit 9 -> 0 carries onward
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD -1 with ripple borrow; each digit 0 -> 9 borrows onward
  function automatic logic [SW-1:0] bcd_dec(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Two-flop synchroniser plus history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= touch;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign inc = s2 & ~s3;

  // Score status: all-9s, zero, and most significant nonzero digit
  always_comb begin
    all_nines = 1'b1;
    msd       = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (score[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (score[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
    is_zero = (score == '0);
    blank   = (LZB != 0) && (idx > msd);
  end

  // Next score/ovf/wrap with priority clr > inc&dec > inc > dec
  always_comb begin
    score_nxt = score;
    ovf_nxt   = ovf;
    wrap_nxt  = 1'b0;
    if (clr) begin
      score_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (inc && !dec) begin
      if (all_nines) begin
        ovf_nxt = 1'b1;
        if (SATURATE == 0) begin
          score_nxt = '0;
          wrap_nxt  = 1'b1;
        end
      end else begin
        score_nxt = bcd_inc(score);
      end
    end else if (dec && !inc && !is_zero) begin
      score_nxt = bcd_dec(score);
    end
  end

  // Score, flags and best-score registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= '0;
      best  <= '0;
      ovf   <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      score <= score_nxt;
      ovf   <= ovf_nxt;
      wrap  <= wrap_nxt;
      if (score > best) best <= score;
    end
  end

  // Scan divider and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_W'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Registered display outputs for the currently selected digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssd_ctl   <= ~DIGITS'(1);
      ssd_digit <= 4'd0;
      ssd_blank <= 1'b0;
    end else begin
      ssd_ctl   <= ~(DIGITS'(1) << idx);
      ssd_digit <= score[{idx, 2'b00} +: 4];
      ssd_blank <= blank;
    end
  end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Randomized + directed bench for bcd_score_counter (saturating and wrapping
// instances) against an integer-arithmetic reference model.
module tb_bcd_score_counter;

  localparam int unsigned D    = 4;
  localparam int unsigned SD   = 4;
  localparam int          MAXV = 9999;

  logic clk = 1'b0;
  logic rst_n, touch, dec, clr;

  logic [4*D-1:0] score_s, best_s, score_w, best_w;
  logic           ovf_s, wrap_s, blank_s, ovf_w, wrap_w, blank_w;
  logic [D-1:0]   ctl_s, ctl_w;
  logic [3:0]     dig_s, dig_w;

  always #5 clk = ~clk;

  bcd_score_counter #(.DIGITS(D), .SATURATE(1), .SCAN_DIV(SD), .LZB(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .touch(touch), .dec(dec), .clr(clr),
    .score(score_s), .best(best_s), .ovf(ovf_s), .wrap(wrap_s),
    .ssd_ctl(ctl_s), .ssd_digit(dig_s), .ssd_blank(blank_s));

  bcd_score_counter #(.DIGITS(D), .SATURATE(0), .SCAN_DIV(SD), .LZB(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .touch(touch), .dec(dec), .clr(clr),
    .score(score_w), .best(best_w), .ovf(ovf_w), .wrap(wrap_w),
    .ssd_ctl(ctl_w), .ssd_digit(dig_w), .ssd_blank(blank_w));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int digit_of(input int v, input int i);
    int p;
    p = 1;
    repeat (i) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < int'(D); i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic int msd_of(input int v);
    int m;
    m = 0;
    for (int i = 0; i < int'(D); i++) if (digit_of(v, i) != 0) m = i;
    return m;
  endfunction

  // Reference model: integer score, touch sample history as a queue
  int       m_score [2];
  int       m_best  [2];
  bit       m_ovf   [2];
  bit       m_wrap  [2];
  int       m_dig   [2];
  bit       m_blank [2];
  bit       sat_k   [2] = '{1'b1, 1'b0};
  bit       lzb_k   [2] = '{1'b1, 1'b0};
  logic [D-1:0] m_ctl;
  int       m_div, m_idx;
  bit       th[$];
  bit       m_inc;
  bit       chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_score[k] = 0; m_best[k] = 0; m_ovf[k] = 0; m_wrap[k] = 0;
        m_dig[k] = 0; m_blank[k] = 0;
      end
      m_ctl = ~D'(1);
      m_div = 0;
      m_idx = 0;
      th = '{1'b0, 1'b0, 1'b0};
    end else begin
      // th[0..2] = touch seen at the previous 1..3 edges
      m_inc = th[1] && !th[2];
      th.push_front(touch);
      void'(th.pop_back());
      m_ctl = ~(D'(1) << m_idx);
      for (int k = 0; k < 2; k++) begin
        m_dig[k]   = digit_of(m_score[k], m_idx);
        m_blank[k] = lzb_k[k] && (m_idx > msd_of(m_score[k]));
        if (m_score[k] > m_best[k]) m_best[k] = m_score[k];
        m_wrap[k] = 0;
        if (clr) begin
          m_score[k] = 0;
          m_ovf[k]   = 0;
        end else if (m_inc && !dec) begin
          if (m_score[k] == MAXV) begin
            m_ovf[k] = 1;
            if (!sat_k[k]) begin
              m_score[k] = 0;
              m_wrap[k]  = 1;
            end
          end else begin
            m_score[k]++;
          end
        end else if (dec && !m_inc && m_score[k] > 0) begin
          m_score[k]--;
        end
      end
      if (m_div == SD - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % D;
      end else begin
        m_div++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("score_s", score_s, to_bcd(m_score[0]));
      check("best_s",  best_s,  to_bcd(m_best[0]));
      check("ovf_s",   ovf_s,   m_ovf[0]);
      check("wrap_s",  wrap_s,  m_wrap[0]);
      check("ctl_s",   ctl_s,   m_ctl);
      check("dig_s",   dig_s,   m_dig[0]);
      check("blank_s", blank_s, m_blank[0]);
      check("score_w", score_w, to_bcd(m_score[1]));
      check("best_w",  best_w,  to_bcd(m_best[1]));
      check("ovf_w",   ovf_w,   m_ovf[1]);
      check("wrap_w",  wrap_w,  m_wrap[1]);
      check("ctl_w",   ctl_w,   m_ctl);
      check("dig_w",   dig_w,   m_dig[1]);
      check("blank_w", blank_w, m_blank[1]);
    end
  end

  int wcnt_s = 0;
  int wcnt_w = 0;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (wrap_s) wcnt_s++;
      if (wrap_w) wcnt_w++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic touch_slow();
    touch = 1'b1; tick(5);
    touch = 1'b0; tick(5);
  endtask

  task automatic touches_fast(input int n);
    repeat (n) begin
      touch = 1'b1; tick(1);
      touch = 1'b0; tick(1);
    end
    tick(3);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(1);
    clr = 1'b0; tick(2);
  endtask

  logic [D-1:0] exp_ctl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0]   exp_dig [4] = '{4'd2, 4'd4, 4'd0, 4'd0};
  logic         exp_blk [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int w;
    touch = 1'b0; dec = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_score", score_s, 16'h0000);
    check("rst_best",  best_s,  16'h0000);
    check("rst_ovf",   ovf_s,   1'b0);
    check("rst_wrap",  wrap_w,  1'b0);
    check("rst_ctl",   ctl_s,   4'b1110);
    check("rst_dig",   dig_s,   4'd0);
    check("rst_blank", blank_s, 1'b0);
    tick(2);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick(2);

    repeat (12) touch_slow();
    check("twelve_score", score_s, 16'h0012);
    check("twelve_best",  best_s,  16'h0012);
    check("twelve_ovf",   ovf_s,   1'b0);

    touch = 1'b1; tick(1000); touch = 1'b0; tick(4);
    check("hold_one_inc", score_s, 16'h0013);

    touches_fast(999 - 13);
    check("pre_0999", score_s, 16'h0999);
    touches_fast(1);
    check("carry_1000", score_s, 16'h1000);
    dec = 1'b1; tick(1); dec = 1'b0; tick(1);
    check("borrow_0999", score_s, 16'h0999);
    dec = 1'b1; tick(1000); dec = 1'b0; tick(2);
    check("dec_floor", score_s, 16'h0000);
    check("best_1000", best_s,  16'h1000);

    touches_fast(5);
    check("pre_5", score_s, 16'h0005);
    touch = 1'b1; tick(1); touch = 1'b0; tick(1);
    dec = 1'b1; tick(1); dec = 1'b0; tick(3);
    check("inc_dec_same", score_s, 16'h0005);
    touch = 1'b1; tick(1); touch = 1'b0; tick(1);
    clr = 1'b1; tick(1); clr = 1'b0; tick(3);
    check("clr_over_inc", score_s, 16'h0000);

    repeat (3000) begin
      touch = 1'($urandom_range(0, 1));
      dec   = ($urandom_range(0, 15) == 0);
      clr   = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    touch = 1'b0; dec = 1'b0; clr = 1'b0; tick(4);

    pulse_clr();
    touches_fast(MAXV);
    check("top_s", score_s, 16'h9999);
    check("top_w", score_w, 16'h9999);
    wcnt_s = 0; wcnt_w = 0;
    touches_fast(1);
    tick(3);
    check("wrap_score", score_w, 16'h0000);
    check("wrap_ovf",   ovf_w,   1'b1);
    check("wrap_once",  wcnt_w,  1);
    touches_fast(2);
    check("sat_score", score_s, 16'h9999);
    check("sat_ovf",   ovf_s,   1'b1);
    check("sat_nowrap", wcnt_s, 0);
    pulse_clr();
    check("clr_score", score_s, 16'h0000);
    check("clr_ovf",   ovf_s,   1'b0);
    check("clr_best",  best_s,  16'h9999);

    touches_fast(42);
    w = 0;
    while (ctl_s !== 4'b0111 && w < 40) begin tick(1); w++; end
    while (ctl_s === 4'b0111 && w < 40) begin tick(1); w++; end
    check("scan_sync", (w < 40), 1);
    for (int j = 0; j < 16; j++) begin
      check("scan_ctl",   ctl_s,   exp_ctl[j/4]);
      check("scan_dig",   dig_s,   exp_dig[j/4]);
      check("scan_blank", blank_s, exp_blk[j/4]);
      tick(1);
    end

    tick(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctl",   ctl_s,   4'b1110);
    check("midrst_score", score_s, 16'h0000);
    check("midrst_best",  best_w,  16'h0000);
    tick(2);
    rst_n = 1'b1;
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
